// File: rtl/y_enhance_ctrl.sv
// Per-frame luma statistics and gain controller for the Y-enhancement datapath.
// Tracks min/max Y per frame and derives a Q8.8 stretch gain with a serial divider.
module y_enhance_ctrl #(
    parameter int MIN_DIFF  = 16,
    parameter int NUMERATOR = 65280,
    parameter int DEF_RATE  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] video_in_data,
    input  logic        video_in_valid,
    input  logic        video_in_ready,
    input  logic        video_in_sop,
    input  logic        video_in_eop,
    input  logic        ctrl_enable,
    input  logic [15:0] manual_rate,
    input  logic [7:0]  manual_min,
    output logic [15:0] rate,
    output logic [7:0]  min_value,
    output logic        diff2small,
    output logic        stats_valid,
    output logic        busy,
    output logic        overrun
);

    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  ACCUM  = 2'd1;
    localparam logic [1:0]  DIVIDE = 2'd2;
    localparam logic [7:0]  MIN_DIFF_C  = 8'(MIN_DIFF);
    localparam logic [15:0] NUMERATOR_C = 16'(NUMERATOR);
    localparam logic [15:0] DEF_RATE_C  = 16'(DEF_RATE);

    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (b < a) ? b : a;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (b > a) ? b : a;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [7:0]  min_q, min_d, max_q, max_d;
    logic [7:0]  div_q, div_d, base_q, base_d;
    logic [7:0]  rem_q, rem_d;
    logic [15:0] quo_q, quo_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [15:0] rate_q;
    logic [7:0]  min_value_q;
    logic        diff2small_q, stats_valid_q;

    logic        acc_s, eval_s, done_s, small_s, ge_s;
    logic [7:0]  y_s, diff_s, rem_nx_s, rem_sub_s;
    logic [8:0]  rem_sh_s;
    logic [15:0] quo_nx_s;
    logic        unused_s;

    assign acc_s    = video_in_valid & video_in_ready;
    assign y_s      = video_in_data[23:16];
    assign unused_s = ^video_in_data[15:0];

    // One restoring-division step; remainder stays below the 8-bit divisor, so
    // the low 8 bits of the subtraction are exact.
    assign rem_sh_s  = {rem_q, quo_q[15]};
    assign ge_s      = (rem_sh_s >= {1'b0, div_q});
    assign rem_sub_s = rem_sh_s[7:0] - div_q;
    assign rem_nx_s  = ge_s ? rem_sub_s : rem_sh_s[7:0];
    assign quo_nx_s  = {quo_q[14:0], ge_s};

    // Next-state logic: frame tracking, end-of-frame evaluation and division.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        div_d   = div_q;
        base_d  = base_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        ovr_d   = 1'b0;
        eval_s  = 1'b0;
        done_s  = 1'b0;
        small_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (acc_s && video_in_sop) begin
                    min_d = y_s;
                    max_d = y_s;
                    if (video_in_eop) begin
                        eval_s = 1'b1;
                    end else begin
                        state_d = ACCUM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (acc_s) begin
                    if (video_in_sop) begin
                        min_d = y_s;
                        max_d = y_s;
                    end else begin
                        min_d = min8(min_q, y_s);
                        max_d = max8(max_q, y_s);
                    end
                    eval_s = video_in_eop;
                end else begin
                    state_d = ACCUM;
                end
            end
            DIVIDE: begin
                rem_d = rem_nx_s;
                quo_d = quo_nx_s;
                cnt_d = cnt_q + 4'd1;
                // A frame starting during the division accumulates in parallel;
                // one ending here is dropped.
                if (acc_s) begin
                    if (video_in_sop) begin
                        min_d = y_s;
                        max_d = y_s;
                    end else if (pend_q) begin
                        min_d = min8(min_q, y_s);
                        max_d = max8(max_q, y_s);
                    end else begin
                        min_d = min_q;
                    end
                    if (video_in_eop) begin
                        pend_d = 1'b0;
                        ovr_d  = 1'b1;
                    end else if (video_in_sop) begin
                        pend_d = 1'b1;
                    end else begin
                        pend_d = pend_q;
                    end
                end else begin
                    pend_d = pend_q;
                end
                if (cnt_q == 4'd15) begin
                    done_s  = 1'b1;
                    state_d = pend_d ? ACCUM : IDLE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = DIVIDE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        diff_s = max_d - min_d;
        if (eval_s && (diff_s < MIN_DIFF_C)) begin
            small_s = 1'b1;
            state_d = IDLE;
        end else if (eval_s) begin
            div_d   = diff_s;
            base_d  = min_d;
            rem_d   = 8'd0;
            quo_d   = NUMERATOR_C;
            cnt_d   = 4'd0;
            state_d = DIVIDE;
        end else begin
            small_s = 1'b0;
        end
    end

    // Control and statistics state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            min_q   <= 8'd0;
            max_q   <= 8'd0;
            div_q   <= 8'd0;
            base_q  <= 8'd0;
            rem_q   <= 8'd0;
            quo_q   <= 16'd0;
            cnt_q   <= 4'd0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            div_q   <= div_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
        end
    end

    // Parameter outputs to the datapath; manual override wins every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rate_q        <= DEF_RATE_C;
            min_value_q   <= 8'd0;
            diff2small_q  <= 1'b0;
            stats_valid_q <= 1'b0;
        end else if (!ctrl_enable) begin
            rate_q        <= manual_rate;
            min_value_q   <= manual_min;
            diff2small_q  <= 1'b0;
            stats_valid_q <= 1'b0;
        end else if (small_s) begin
            rate_q        <= DEF_RATE_C;
            min_value_q   <= 8'd0;
            diff2small_q  <= 1'b1;
            stats_valid_q <= 1'b1;
        end else if (done_s) begin
            rate_q        <= quo_nx_s;
            min_value_q   <= base_q;
            diff2small_q  <= 1'b0;
            stats_valid_q <= 1'b1;
        end else begin
            stats_valid_q <= 1'b0;
        end
    end

    assign rate        = rate_q;
    assign min_value   = min_value_q;
    assign diff2small  = diff2small_q;
    assign stats_valid = stats_valid_q;
    assign busy        = (state_q == DIVIDE);
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_y_enhance_ctrl.sv
// Directed bench for y_enhance_ctrl: drives frames and checks published gain,
// black level, flags and timing against hand-computed values.
module tb_y_enhance_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] video_in_data;
    logic        video_in_valid, video_in_ready, video_in_sop, video_in_eop;
    logic        ctrl_enable;
    logic [15:0] manual_rate;
    logic [7:0]  manual_min;
    logic [15:0] rate;
    logic [7:0]  min_value;
    logic        diff2small, stats_valid, busy, overrun;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Frame 1 spans 50..150 (gain 65280/100 = 652); frame 2 spans the full range.
    logic [7:0] f1 [10] = '{8'd50, 8'd90, 8'd150, 8'd70, 8'd120, 8'd60, 8'd80, 8'd100, 8'd140, 8'd110};
    logic [7:0] f2 [10] = '{8'd0, 8'd255, 8'd128, 8'd3, 8'd250, 8'd128, 8'd9, 8'd200, 8'd1, 8'd128};

    y_enhance_ctrl dut (
        .clk(clk), .rst(rst),
        .video_in_data(video_in_data), .video_in_valid(video_in_valid),
        .video_in_ready(video_in_ready), .video_in_sop(video_in_sop),
        .video_in_eop(video_in_eop), .ctrl_enable(ctrl_enable),
        .manual_rate(manual_rate), .manual_min(manual_min),
        .rate(rate), .min_value(min_value), .diff2small(diff2small),
        .stats_valid(stats_valid), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic set_beat(input logic [7:0] y, input logic s, input logic e, input logic r);
        video_in_data  = {y, 8'h80, 8'h80};
        video_in_valid = 1'b1;
        video_in_ready = r;
        video_in_sop   = s;
        video_in_eop   = e;
    endtask

    task automatic set_idle();
        video_in_valid = 1'b0;
        video_in_ready = 1'b1;
        video_in_sop   = 1'b0;
        video_in_eop   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #12;
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid, busy, overrun} !== {16'h0100, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_values: got rate=%h min=%0d d2s=%b sv=%b busy=%b ovr=%b expected 0100/0/0/0/0/0",
                     rate, min_value, diff2small, stats_valid, busy, overrun);
            err_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if ({rate, busy, stats_valid} !== {16'h0100, 1'b0, 1'b0}) begin
            $display("FAIL reset_release: got rate=%h busy=%b sv=%b expected 0100/0/0", rate, busy, stats_valid);
            err_cnt++;
        end
    endtask

    task automatic test_ramp();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            set_beat(8'(16 + (i * 219) / 63), i == 0, i == 63, 1'b1);
        end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            set_idle();
            vec_cnt++;
            if ({busy, stats_valid} !== 2'b10) begin
                $display("FAIL ramp_busy k=%0d: got busy=%b sv=%b expected busy=1 sv=0", k, busy, stats_valid);
                err_cnt++;
            end
        end
        @(negedge clk);
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid, busy} !== {16'd298, 8'd16, 1'b0, 1'b1, 1'b0}) begin
            $display("FAIL ramp_result: got rate=%h min=%0d d2s=%b sv=%b busy=%b expected 012a/16/0/1/0",
                     rate, min_value, diff2small, stats_valid, busy);
            err_cnt++;
        end
        @(negedge clk);
        vec_cnt++;
        if ({rate, stats_valid} !== {16'd298, 1'b0}) begin
            $display("FAIL ramp_hold: got rate=%h sv=%b expected 012a/0", rate, stats_valid);
            err_cnt++;
        end
    endtask

    task automatic test_small();
        @(negedge clk); set_beat(8'd100, 1'b1, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd105, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd110, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd103, 1'b0, 1'b1, 1'b1);
        @(negedge clk); set_idle();
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid, busy} !== {16'h0100, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL small_result: got rate=%h min=%0d d2s=%b sv=%b busy=%b expected 0100/0/1/1/0",
                     rate, min_value, diff2small, stats_valid, busy);
            err_cnt++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({busy, stats_valid} !== 2'b00) begin
                $display("FAIL small_quiet k=%0d: got busy=%b sv=%b expected 0/0", k, busy, stats_valid);
                err_cnt++;
            end
        end
    endtask

    task automatic test_full_range();
        @(negedge clk); set_beat(8'd128, 1'b1, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd0,   1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd255, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd7,   1'b0, 1'b1, 1'b1);
        repeat (16) begin
            @(negedge clk);
            set_idle();
        end
        @(negedge clk);
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid} !== {16'h0100, 8'd0, 1'b0, 1'b1}) begin
            $display("FAIL full_range: got rate=%h min=%0d d2s=%b sv=%b expected 0100/0/0/1",
                     rate, min_value, diff2small, stats_valid);
            err_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_beat(f1[i], i == 0, i == 9, 1'b1);
        end
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({overrun, busy, stats_valid} !== {k == 11, k <= 16, k == 17}) begin
                $display("FAIL b2b_flags k=%0d: got ovr=%b busy=%b sv=%b expected %b/%b/%b",
                         k, overrun, busy, stats_valid, k == 11, k <= 16, k == 17);
                err_cnt++;
            end
            if (k <= 10) set_beat(f2[k-1], k == 1, k == 10, 1'b1);
            else set_idle();
        end
        vec_cnt++;
        if ({rate, min_value, diff2small} !== {16'd652, 8'd50, 1'b0}) begin
            $display("FAIL b2b_result: got rate=%h min=%0d d2s=%b expected 028c/50/0", rate, min_value, diff2small);
            err_cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rate, stats_valid, busy} !== {16'd652, 1'b0, 1'b0}) begin
                $display("FAIL b2b_second_ignored k=%0d: got rate=%h sv=%b busy=%b expected 028c/0/0",
                         k, rate, stats_valid, busy);
                err_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_beat(f1[i], i == 0, i == 9, 1'b1);
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            set_idle();
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid, busy, overrun} !== {16'h0100, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL reset_mid: got rate=%h min=%0d d2s=%b sv=%b busy=%b ovr=%b expected 0100/0/0/0/0/0",
                     rate, min_value, diff2small, stats_valid, busy, overrun);
            err_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rate, min_value, stats_valid, busy} !== {16'h0100, 8'd0, 1'b0, 1'b0}) begin
                $display("FAIL reset_mid_quiet k=%0d: got rate=%h min=%0d sv=%b busy=%b expected 0100/0/0/0",
                         k, rate, min_value, stats_valid, busy);
                err_cnt++;
            end
            set_beat(8'(k * 8), 1'b0, (k % 5) == 4, 1'b1);
        end
        @(negedge clk);
        set_idle();
    endtask

    task automatic test_manual();
        ctrl_enable = 1'b0;
        manual_rate = 16'h0180;
        manual_min  = 8'd20;
        @(negedge clk);
        vec_cnt++;
        if ({rate, min_value, diff2small} !== {16'h0180, 8'd20, 1'b0}) begin
            $display("FAIL manual_apply: got rate=%h min=%0d d2s=%b expected 0180/20/0", rate, min_value, diff2small);
            err_cnt++;
        end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            set_beat(8'(16 + (i * 219) / 63), i == 0, i == 63, 1'b1);
        end
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            set_idle();
            vec_cnt++;
            if ({rate, min_value, stats_valid} !== {16'h0180, 8'd20, 1'b0}) begin
                $display("FAIL manual_hold k=%0d: got rate=%h min=%0d sv=%b expected 0180/20/0",
                         k, rate, min_value, stats_valid);
                err_cnt++;
            end
        end
        ctrl_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vec_cnt++;
            if ({rate, min_value, stats_valid} !== {16'h0180, 8'd20, 1'b0}) begin
                $display("FAIL manual_keep k=%0d: got rate=%h min=%0d sv=%b expected 0180/20/0",
                         k, rate, min_value, stats_valid);
                err_cnt++;
            end
        end
    endtask

    task automatic test_ready_gating();
        @(negedge clk); set_beat(8'd60,  1'b1, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd0,   1'b0, 1'b0, 1'b0);
        @(negedge clk); set_beat(8'd255, 1'b0, 1'b0, 1'b0);
        @(negedge clk); set_beat(8'd110, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd9,   1'b0, 1'b1, 1'b0);
        @(negedge clk); set_beat(8'd160, 1'b0, 1'b0, 1'b1);
        @(negedge clk); set_beat(8'd250, 1'b1, 1'b0, 1'b0);
        @(negedge clk); set_beat(8'd90,  1'b0, 1'b1, 1'b1);
        repeat (16) begin
            @(negedge clk);
            set_idle();
        end
        @(negedge clk);
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid} !== {16'd652, 8'd60, 1'b0, 1'b1}) begin
            $display("FAIL ready_gating: got rate=%h min=%0d d2s=%b sv=%b expected 028c/60/0/1",
                     rate, min_value, diff2small, stats_valid);
            err_cnt++;
        end
    endtask

    task automatic test_one_pixel();
        @(negedge clk); set_beat(8'd77, 1'b1, 1'b1, 1'b1);
        @(negedge clk); set_idle();
        vec_cnt++;
        if ({rate, min_value, diff2small, stats_valid, busy} !== {16'h0100, 8'd0, 1'b1, 1'b1, 1'b0}) begin
            $display("FAIL one_pixel: got rate=%h min=%0d d2s=%b sv=%b busy=%b expected 0100/0/1/1/0",
                     rate, min_value, diff2small, stats_valid, busy);
            err_cnt++;
        end
    endtask

    initial begin
        video_in_data = 24'd0;
        set_idle();
        ctrl_enable = 1'b1;
        manual_rate = 16'd0;
        manual_min  = 8'd0;
        test_reset();
        test_ramp();
        test_small();
        test_full_range();
        test_back_to_back();
        test_reset_mid();
        test_manual();
        test_ready_gating();
        test_one_pixel();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/y_enhance_ctrl.md
Name: y_enhance_ctrl

Overview:
Per-frame statistics and parameter controller for the Y-enhancement datapath. It snoops the 24-bit YCbCr Avalon-ST video stream (Y in bits [23:16]) and tracks the minimum and maximum Y of each frame. At end of frame it computes a Q8.8 stretch gain with a sequential divider. It drives rate, min_value and diff2small to the enhancement calculator, which latches them at its own end-of-frame, so statistics from frame N take effect on frame N+1 output.

Parameters:
MIN_DIFF, 16, frames with (maxY - minY) < MIN_DIFF are flagged diff2small and get unity gain
NUMERATOR, 65280, dividend for gain: 255 in Q8.8 (255*256)
DEF_RATE, 256, rate output after reset and for diff2small frames (1.0 in Q8.8)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
video_in_data  in  24  snooped pixel; Y = [23:16]
video_in_valid  in  1  snooped valid
video_in_ready  in  1  snooped ready; a beat is accepted when valid & ready
video_in_sop  in  1  start of frame, qualified by accepted beat
video_in_eop  in  1  end of frame, qualified by accepted beat
ctrl_enable  in  1  1 = automatic gain; 0 = manual override
manual_rate  in  16  rate used when ctrl_enable = 0
manual_min  in  8  min_value used when ctrl_enable = 0
rate  out  16  Q8.8 gain to datapath
min_value  out  8  black level to datapath
diff2small  out  1  low-contrast flag to datapath
stats_valid  out  1  one-cycle pulse when rate/min_value/diff2small update
busy  out  1  high while state = DIVIDE
overrun  out  1  one-cycle pulse when an eop is accepted during DIVIDE

Behaviour:
- Reset values: rate = DEF_RATE, min_value = 0, diff2small = 0, stats_valid = 0, busy = 0, overrun = 0; state IDLE; min/max registers 0.
- States: IDLE, ACCUM, DIVIDE.
- IDLE: accepted beat with sop -> ACCUM; minY = maxY = Y. Beats without sop are ignored.
- ACCUM, per accepted beat:
  - minY = min(minY, Y); maxY = max(maxY, Y).
  - A new sop restarts: minY = maxY = Y.
  - An eop beat's Y is included before evaluation.
  - sop and eop on the same beat is a one-pixel frame: diff = 0.
- On accepted eop (cycle T), with diff = maxY' - minY' (8-bit, never negative):
  - If diff < MIN_DIFF: at T+1 set rate = DEF_RATE, min_value = 0, diff2small = 1, stats_valid = 1; -> IDLE. DIVIDE is skipped.
  - Else: capture diff and minY', -> DIVIDE at T+1.
- DIVIDE: restoring division of NUMERATOR (16 bit) by diff (8 bit), one quotient bit per cycle, 16 cycles (T+1..T+16). busy = 1 during these cycles.
  - At T+17: rate = quotient (16 bit, exact floor), min_value = captured minY, diff2small = 0, stats_valid = 1; -> IDLE.
  - diff >= 1 is guaranteed here, so there is no divide-by-zero. Maximum quotient is 65280, which fits 16 bits.
- Accepted eop while in DIVIDE: the frame is dropped, overrun pulses 1 cycle, and the division continues undisturbed.
- Accepted sop while in DIVIDE: accumulation starts in parallel (min/max are loaded). State returns to ACCUM rather than IDLE after the division completes.
- ctrl_enable = 0: each cycle rate <= manual_rate, min_value <= manual_min, diff2small <= 0. Statistics still run, but their result is discarded and stats_valid is not pulsed. Returning to 1 keeps the manual values until the next stats_valid.
- Outputs are held stable between updates.
- Reset mid-operation aborts any division and restores reset values immediately.

Test Plan:
- Frame of 64 beats, Y ramping 16..235 with sop/eop -> 17 cycles after eop: rate = 0x012A (298), min_value = 16, diff2small = 0, stats_valid single pulse; busy high 16 cycles.
- Frame with Y in 0..255 -> rate = 0x0100, min_value = 0.
- Frame with Y in 100..110, MIN_DIFF = 16 -> one cycle after eop: rate = 0x0100, min_value = 0, diff2small = 1, busy never asserted.
- Two frames of 10 beats back-to-back (second eop lands in DIVIDE) -> overrun pulse; first frame's results published; second frame ignored.
- Assert rst at DIVIDE cycle 8 -> outputs return to reset values asynchronously; no stats_valid afterwards until a new complete frame arrives.
- ctrl_enable = 0, manual_rate = 0x0180, manual_min = 20, stream a frame -> rate = 0x0180, min_value = 20, no stats_valid; valid = 1 with ready = 0 beats must not affect min/max.
